// File: rtl/hdmi_sched_pkg.sv
// hdmi_sched_pkg: shared types and helpers for the HDMI FIFO read scheduler
package hdmi_sched_pkg;
  typedef enum logic [1:0] {SEEK, WAIT_VS, RUN} state_t;
  localparam logic [15:0] CNT_SAT = 16'hFFFF;
  function automatic int sof_idx(input int data_w);
    return data_w - 1;
  endfunction
  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
    return (en && c != CNT_SAT) ? c + 16'd1 : c;
  endfunction
endpackage

// File: rtl/hdmi_fifo_rd_sched_if.sv
// hdmi_fifo_rd_sched_if: FIFO read port, video timing and pixel output bundle
interface hdmi_fifo_rd_sched_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_vld;
  logic              fifo_rd_en;
  logic              vid_vs;
  logic              vid_de;
  logic [DATA_W-2:0] pix_data;
  logic              pix_vld;
  logic              locked;
  logic [15:0]       frame_cnt;
  logic [15:0]       err_cnt;
  modport master (
    output fifo_rd_data, fifo_rd_vld, vid_vs, vid_de,
    input  fifo_rd_en, pix_data, pix_vld, locked, frame_cnt, err_cnt
  );
  modport slave (
    input  fifo_rd_data, fifo_rd_vld, vid_vs, vid_de,
    output fifo_rd_en, pix_data, pix_vld, locked, frame_cnt, err_cnt
  );
endinterface

// File: rtl/hdmi_sched_pos_cnt.sv
// hdmi_sched_pos_cnt: x/y active-pixel position counter with line/frame end flags
module hdmi_sched_pos_cnt #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int CNT_W    = 12
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_end,
  output logic             frame_end
);
  assign line_end  = x == CNT_W'(H_ACTIVE - 1);
  assign frame_end = line_end && y == CNT_W'(V_ACTIVE - 1);
  always_ff @(posedge rd_clk) begin
    if (rd_rst || clr) begin
      x <= '0;
      y <= '0;
    end else if (inc) begin
      x <= line_end ? '0 : x + CNT_W'(1);
      y <= frame_end ? '0 : line_end ? y + CNT_W'(1) : y;
    end
  end
endmodule

// File: rtl/hdmi_fifo_rd_sched.sv
// hdmi_fifo_rd_sched: pops one FIFO word per active pixel, aligns FIFO frames to display frames via SOF tag.
// Optional stats counters enabled by `HDMI_SCHED_STATS_EN.
module hdmi_fifo_rd_sched
  import hdmi_sched_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              H_ACTIVE = 1280,
  parameter int              V_ACTIVE = 720,
  parameter int              CNT_W    = 12,
  parameter logic [DATA_W-2:0] FILL_PIX = '0
) (
  input logic                rd_clk,
  input logic                rd_rst,
  hdmi_fifo_rd_sched_if.slave bus
);
  localparam int SOF = sof_idx(DATA_W);
  state_t            state, state_nxt;
  logic              err_flag, err_flag_nxt;
  logic [CNT_W-1:0]  x, y;
  logic              line_end, frame_end;
  logic              sof, head_sof, at_origin, abort, inc, pop, miss, last;
  logic [DATA_W-2:0] pix_q;
  logic              pix_vld_q;
  hdmi_sched_pos_cnt #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .CNT_W(CNT_W)) u_pos (
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .inc       (inc),
    .clr       (state != RUN),
    .x         (x),
    .y         (y),
    .line_end  (line_end),
    .frame_end (frame_end)
  );
  always_comb begin
    sof       = bus.fifo_rd_data[SOF];
    head_sof  = bus.fifo_rd_vld && sof;
    at_origin = x == '0 && y == '0;
    abort     = state == RUN && bus.vid_vs && !at_origin;
    inc       = state == RUN && !abort && bus.vid_de;
    pop       = inc && bus.fifo_rd_vld && (sof == at_origin);
    miss      = inc && !pop;
    last      = inc && frame_end;
  end
  // Reset also blocks the pop so a mid-frame reset leaves the FIFO untouched
  assign bus.fifo_rd_en = !rd_rst && (state == SEEK ? bus.fifo_rd_vld && !sof : pop);
  assign bus.locked     = state == RUN && !err_flag;
  assign bus.pix_data   = pix_q;
  assign bus.pix_vld    = pix_vld_q;
  always_comb begin
    state_nxt    = state;
    err_flag_nxt = err_flag || miss;
    case (state)
      SEEK:    state_nxt = head_sof ? WAIT_VS : SEEK;
      WAIT_VS: begin
        if (bus.vid_vs && head_sof) begin
          state_nxt    = RUN;
          err_flag_nxt = 1'b0;
        end else if (bus.fifo_rd_vld && !sof) state_nxt = SEEK;
      end
      RUN:     state_nxt = abort ? SEEK : last ? (err_flag_nxt ? SEEK : WAIT_VS) : RUN;
      default: state_nxt = SEEK;
    endcase
  end
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state     <= SEEK;
      err_flag  <= 1'b0;
      pix_q     <= FILL_PIX;
      pix_vld_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      err_flag  <= err_flag_nxt;
      pix_q     <= pop ? bus.fifo_rd_data[DATA_W-2:0] : FILL_PIX;
      pix_vld_q <= bus.vid_de;
    end
  end
`ifdef HDMI_SCHED_STATS_EN
  logic [15:0] frame_cnt, err_cnt;
  logic        frame_inc, err_inc;
  assign frame_inc = last && !err_flag_nxt;
  assign err_inc   = (state == WAIT_VS && bus.vid_vs && !head_sof) || abort || (miss && !err_flag);
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      frame_cnt <= sat_inc(frame_cnt, frame_inc);
      err_cnt   <= sat_inc(err_cnt, err_inc);
    end
  end
  assign bus.frame_cnt = frame_cnt;
  assign bus.err_cnt   = err_cnt;
`else
  assign bus.frame_cnt = 16'h0;
  assign bus.err_cnt   = 16'h0;
`endif
endmodule
